// File: rtl/sign_mag_sub_serial_if.sv
// Operand/result handshake bundle for the bit-serial sign-magnitude subtractor.
interface sign_mag_sub_serial_if #(parameter int N = 4);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] Diff;
  logic         ovf;

  modport master (output in_valid, A, B, out_ready,
                  input  in_ready, out_valid, Diff, ovf);
  modport slave  (input  in_valid, A, B, out_ready,
                  output in_ready, out_valid, Diff, ovf);
endinterface

// File: rtl/sign_mag_sub_serial.sv
// Bit-serial sign-magnitude subtractor: Diff = A - B, one magnitude bit per clock,
// LSB first, with valid/ready handshakes on both sides.
module sign_mag_sub_serial #(
  parameter int N = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  sign_mag_sub_serial_if.slave  bus
);
  localparam int M  = N - 1;
  localparam int CW = (M > 1) ? $clog2(M) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [M-1:0]   max_q, max_d;
  logic [M-1:0]   min_q, min_d;
  logic [M-1:0]   res_q, res_d;
  logic           sub_q, sub_d;
  logic           sign_q, sign_d;
  logic           c_q, c_d;
  logic [N-1:0]   diff_q, diff_d;
  logic           ovf_q, ovf_d;

  logic           sign_a, sign_be;
  logic [M-1:0]   mag_a, mag_b;
  logic           a_bit, b_bit, r_bit, carry, borrow, c_next;
  logic [M:0]     res_shift;
  logic [M-1:0]   res_next;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    max_d   = max_q;
    min_d   = min_q;
    res_d   = res_q;
    sub_d   = sub_q;
    sign_d  = sign_q;
    c_d     = c_q;
    diff_d  = diff_q;
    ovf_d   = ovf_q;

    sign_a  = bus.A[N-1];
    sign_be = ~bus.B[N-1];
    mag_a   = bus.A[M-1:0];
    mag_b   = bus.B[M-1:0];

    // max/min are shifted right each cycle so bit 0 is always the current bit
    a_bit     = max_q[0];
    b_bit     = min_q[0];
    r_bit     = a_bit ^ b_bit ^ c_q;
    carry     = (a_bit & b_bit) | (c_q & (a_bit ^ b_bit));
    borrow    = (~a_bit & b_bit) | (c_q & ~(a_bit ^ b_bit));
    c_next    = sub_q ? borrow : carry;
    res_shift = {r_bit, res_q} >> 1;
    res_next  = res_shift[M-1:0];

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = CALC;
          cnt_d   = '0;
          c_d     = 1'b0;
          res_d   = '0;
          sub_d   = (sign_a != sign_be);
          if (mag_a > mag_b) begin
            max_d  = mag_a;
            min_d  = mag_b;
            sign_d = sign_a;
          end else begin
            max_d  = mag_b;
            min_d  = mag_a;
            sign_d = sign_be;
          end
        end
      end
      CALC: begin
        res_d = res_next;
        c_d   = c_next;
        max_d = max_q >> 1;
        min_d = min_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(M - 1)) begin
          state_d = DONE;
          ovf_d   = ~sub_q & c_next;
          // a zero magnitude without overflow is always reported as +0
          diff_d  = {(res_next == '0 && !(~sub_q & c_next)) ? 1'b0 : sign_q, res_next};
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      max_q   <= '0;
      min_q   <= '0;
      res_q   <= '0;
      sub_q   <= 1'b0;
      sign_q  <= 1'b0;
      c_q     <= 1'b0;
      diff_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      max_q   <= max_d;
      min_q   <= min_d;
      res_q   <= res_d;
      sub_q   <= sub_d;
      sign_q  <= sign_d;
      c_q     <= c_d;
      diff_q  <= diff_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.Diff      = diff_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_sign_mag_sub_serial.sv
// Scoreboard bench: driver pushes integer-arithmetic expectations, monitor pops on each
// output handshake and also checks latency, hold-while-stalled and in_ready behaviour.
module tb_sign_mag_sub_serial;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic stall = 1'b0;
  logic [N:0] exp_q[$];

  sign_mag_sub_serial_if #(.N(N)) bus();

  sign_mag_sub_serial #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: signed integer subtraction, then encode as sign-magnitude with wrap.
  function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
    int ma, mb, va, vb, d, m, w;
    logic ov, sg;
    logic [N-2:0] wm;
    ma = int'(a[N-2:0]);
    mb = int'(b[N-2:0]);
    va = a[N-1] ? -ma : ma;
    vb = b[N-1] ? -mb : mb;
    d  = va - vb;
    m  = (d < 0) ? -d : d;
    ov = (m > (2**(N-1) - 1));
    w  = m % (2**(N-1));
    wm = w[N-2:0];
    sg = (d < 0);
    return {sg, wm, ov};
  endfunction

  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic hold);
    int n;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.A = a; bus.B = b;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.in_ready && n < 100);
    if (!bus.in_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout actual=0 required=1");
    end
    exp_q.push_back(model(a, b));
    @(posedge clk); #1;
    bus.in_valid = hold; bus.A = N'($urandom); bus.B = N'($urandom);
    for (int i = 0; i < N - 2; i++) begin
      @(posedge clk); #1;
      bus.A = N'($urandom); bus.B = N'($urandom);
    end
  endtask

  always @(posedge clk) begin
    #1;
    bus.out_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor
  logic         stalled = 1'b0, hs_prev = 1'b0, lat_pend = 1'b0;
  logic [N-1:0] held_diff;
  logic         held_ovf;
  int           acc_cyc;
  logic [N:0]   e;
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0; hs_prev = 1'b0; lat_pend = 1'b0;
    end else begin
      if (stalled) begin
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_diff", 32'({bus.Diff, bus.ovf}), 32'({held_diff, held_ovf}));
      end
      if (hs_prev) chk("in_ready_after_hs", 32'(bus.in_ready), 32'd1);
      if (bus.out_valid) chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
      if (bus.out_valid && lat_pend) begin
        chk("latency", 32'(cyc - acc_cyc), 32'(N));
        lat_pend = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_output actual=%0h required=none", bus.Diff);
        end else begin
          e = exp_q.pop_front();
          chk("diff", 32'(bus.Diff), 32'(e[N:1]));
          chk("ovf", 32'(bus.ovf), 32'(e[0]));
        end
      end
      hs_prev   = bus.out_valid && bus.out_ready;
      stalled   = bus.out_valid && !bus.out_ready;
      held_diff = bus.Diff;
      held_ovf  = bus.ovf;
      if (bus.in_valid && bus.in_ready) begin
        lat_pend = 1'b1;
        acc_cyc  = cyc;
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.out_ready = 1'b0;
    #12;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_diff", 32'(bus.Diff), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    issue(4'b0101, 4'b0011, 1'b0); drain();
    // stalled consumer: result must hold for several cycles
    stall = 1'b1;
    issue(4'b0011, 4'b0101, 1'b0);
    n = 0;
    while (!bus.out_valid && n < 50) begin @(negedge clk); n++; end
    chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
    repeat (5) @(posedge clk);
    stall = 1'b0;
    drain();
    issue(4'b1101, 4'b0011, 1'b0); drain();
    issue(4'b0101, 4'b1011, 1'b0); drain();
    issue(4'b1100, 4'b1100, 1'b0); drain();
    issue(4'b0000, 4'b1000, 1'b0); drain();

    // abort mid-calculation: nothing may be presented
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.A = 4'b0111; bus.B = 4'b0001;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.in_ready && n < 100);
    @(posedge clk); #1; bus.in_valid = 1'b0;
    @(posedge clk); #3; rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk); @(posedge clk); #1; rst_n = 1'b1;
    issue(4'b0010, 4'b0001, 1'b0); drain();

    // back-to-back with in_valid held and operands churning during CALC
    for (int i = 0; i < 4; i++)
      issue(N'($urandom), N'($urandom), 1'b1);
    bus.in_valid = 1'b0;
    drain();

    for (int i = 0; i < 200; i++)
      issue(N'($urandom), N'($urandom), 1'($urandom_range(0, 1)));
    bus.in_valid = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=done");
    $fatal(1, "timeout");
  end
endmodule
